// File: rtl/myminimac_rx_slotctl.sv
// Receive slot controller for the minimal MAC: four CPU-armed buffer slots, one
// of which at a time is handed to the RX datapath and completed into PENDING.
module myminimac_rx_slotctl (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [4:0]  csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  output logic        rx_valid,
  output logic [29:0] rx_adr,
  input  logic        rx_resetcount,
  input  logic        rx_incrcount,
  input  logic        rx_endframe,
  output logic        irq_rx
);

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_LOADED  = 2'd1;
  localparam logic [1:0] ST_PENDING = 2'd2;
  localparam logic [10:0] COUNT_MAX = 11'd2047;

  typedef enum logic {IDLE, ACTIVE} fsm_t;

  fsm_t        fsm_q;
  logic [1:0]  activeIdx_q;
  logic        busy_q;
  logic        rxValid_q;
  logic [29:0] rxAdr_q;
  logic        irq_q;
  logic        irq_d;
  logic [31:0] csrDo_q;
  logic [31:0] csrDo_d;

  logic [1:0]  state_q [4];
  logic [1:0]  state_d [4];
  logic [29:0] adr_q   [4];
  logic [29:0] adr_d   [4];
  logic [10:0] count_q [4];
  logic [10:0] count_d [4];

  logic [1:0]  csrSlot;
  logic        wrState;
  logic        wrAdr;
  logic        activeOk;
  logic        dpEvent;
  logic        cpuDisarm;
  logic        selFound;
  logic [1:0]  selIdx;
  logic        unusedDi;

  assign unusedDi = ^csr_di[31:30];

  // An active slot whose registered state is no longer LOADED (e.g. the CPU
  // emptied it in the very cycle it was selected) is treated as dropped.
  always_comb begin
    csrSlot   = csr_a[3:2];
    wrState   = csr_we && !csr_a[4] && (csr_a[1:0] == 2'd0);
    wrAdr     = csr_we && !csr_a[4] && (csr_a[1:0] == 2'd1);
    activeOk  = (fsm_q == ACTIVE) && (state_q[activeIdx_q] == ST_LOADED);
    dpEvent   = activeOk && (rx_resetcount || rx_incrcount || rx_endframe);
    cpuDisarm = activeOk && !busy_q && !dpEvent && wrState &&
                (csrSlot == activeIdx_q) && (csr_di[1:0] == ST_EMPTY);
    selFound  = 1'b0;
    selIdx    = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (state_q[i] == ST_LOADED) begin
        selFound = 1'b1;
        selIdx   = 2'(i);
      end
    end
  end

  // Datapath events on the active slot take priority over CPU writes to it.
  always_comb begin
    irq_d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      adr_d[i]   = adr_q[i];
      count_d[i] = count_q[i];
      if (dpEvent && (activeIdx_q == 2'(i))) begin
        if (rx_resetcount) begin
          count_d[i] = '0;
        end else begin
          if (rx_incrcount && (count_q[i] != COUNT_MAX))
            count_d[i] = count_q[i] + 11'd1;
          if (rx_endframe)
            state_d[i] = ST_PENDING;
        end
      end else begin
        if (wrState && (csrSlot == 2'(i)) && !csr_di[1] &&
            !(activeOk && (activeIdx_q == 2'(i)) && busy_q)) begin
          state_d[i] = csr_di[1:0];
          count_d[i] = '0;
        end
        if (wrAdr && (csrSlot == 2'(i)) &&
            ((state_q[i] == ST_EMPTY) || (state_q[i] == 2'd3)))
          adr_d[i] = csr_di[29:0];
      end
      if (state_d[i] == ST_PENDING)
        irq_d = 1'b1;
    end
  end

  always_comb begin
    csrDo_d = '0;
    if (csr_a[4]) begin
      if (csr_a[3:0] == 4'd0)
        csrDo_d = {27'd0, busy_q, rxValid_q, 1'b0,
                   rxValid_q ? activeIdx_q : 2'd0};
    end else begin
      case (csr_a[1:0])
        2'd0:    csrDo_d = {30'd0, state_q[csrSlot]};
        2'd1:    csrDo_d = {2'd0, adr_q[csrSlot]};
        2'd2:    csrDo_d = {21'd0, count_q[csrSlot]};
        default: csrDo_d = '0;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= ST_EMPTY;
        adr_q[i]   <= '0;
        count_q[i] <= '0;
      end
      fsm_q       <= IDLE;
      activeIdx_q <= '0;
      busy_q      <= 1'b0;
      rxValid_q   <= 1'b0;
      rxAdr_q     <= '0;
      irq_q       <= 1'b0;
      csrDo_q     <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        adr_q[i]   <= adr_d[i];
        count_q[i] <= count_d[i];
      end
      irq_q   <= irq_d;
      csrDo_q <= csrDo_d;
      case (fsm_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (selFound) begin
            fsm_q       <= ACTIVE;
            activeIdx_q <= selIdx;
            rxValid_q   <= 1'b1;
            rxAdr_q     <= adr_q[selIdx];
          end
        end
        ACTIVE: begin
          if (!activeOk || cpuDisarm ||
              (dpEvent && !rx_resetcount && rx_endframe)) begin
            fsm_q     <= IDLE;
            rxValid_q <= 1'b0;
            busy_q    <= 1'b0;
          end else if (rx_resetcount) begin
            busy_q <= 1'b0;
          end else if (rx_incrcount) begin
            busy_q <= 1'b1;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign csr_do   = csrDo_q;
  assign rx_valid = rxValid_q;
  assign rx_adr   = rxAdr_q;
  assign irq_rx   = irq_q;

endmodule

// File: tb/tb_myminimac_rx_slotctl.sv
// Self-checking bench for myminimac_rx_slotctl: directed scenarios with literal
// expectations, then randomized traffic against a cycle-level slot model.
module tb_myminimac_rx_slotctl;

  logic        sys_clk;
  logic        sys_rst_n;
  logic [4:0]  csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;
  logic        rx_valid;
  logic [29:0] rx_adr;
  logic        rx_resetcount;
  logic        rx_incrcount;
  logic        rx_endframe;
  logic        irq_rx;

  int compared;
  int mismatched;

  // Reference model: slots as plain arrays, active slot as an index (-1 = none)
  logic [1:0]  mState [4];
  logic [29:0] mAdr   [4];
  int          mCount [4];
  int          mActive;
  bit          mBusy;
  logic [29:0] mRxAdr;
  bit          mIrq;
  logic [31:0] mCsrDo;

  myminimac_rx_slotctl dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .csr_a         (csr_a),
    .csr_we        (csr_we),
    .csr_di        (csr_di),
    .csr_do        (csr_do),
    .rx_valid      (rx_valid),
    .rx_adr        (rx_adr),
    .rx_resetcount (rx_resetcount),
    .rx_incrcount  (rx_incrcount),
    .rx_endframe   (rx_endframe),
    .irq_rx        (irq_rx)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic logic [31:0] modelRead(input logic [4:0] a);
    if (a == 5'd16)
      return {27'd0, mBusy, (mActive >= 0), 1'b0,
              (mActive >= 0) ? 2'(mActive) : 2'd0};
    if (a[4] || (a[1:0] == 2'd3))
      return 32'd0;
    case (a[1:0])
      2'd0:    return {30'd0, mState[a[3:2]]};
      2'd1:    return {2'd0, mAdr[a[3:2]]};
      default: return 32'(mCount[a[3:2]]);
    endcase
  endfunction

  task automatic modelStep(input bit rstn, input bit we, input logic [4:0] a,
                           input logic [31:0] di, input bit rc, input bit ic,
                           input bit ef);
    logic [1:0]  nState [4];
    logic [29:0] nAdr   [4];
    int          nCount [4];
    int          nActive;
    bit          nBusy;
    bit          live;
    bit          pulse;
    int          s;
    if (!rstn) begin
      for (int i = 0; i < 4; i++) begin
        mState[i] = 2'd0;
        mAdr[i]   = '0;
        mCount[i] = 0;
      end
      mActive = -1;
      mBusy   = 1'b0;
      mRxAdr  = '0;
      mIrq    = 1'b0;
      mCsrDo  = '0;
      return;
    end
    mCsrDo = modelRead(a);
    for (int i = 0; i < 4; i++) begin
      nState[i] = mState[i];
      nAdr[i]   = mAdr[i];
      nCount[i] = mCount[i];
    end
    nActive = mActive;
    nBusy   = mBusy;
    live    = (mActive >= 0) && (mState[mActive] == 2'd1);
    pulse   = live && (rc || ic || ef);
    if ((mActive >= 0) && !live) begin
      nActive = -1;
      nBusy   = 1'b0;
    end
    if (pulse) begin
      if (rc) begin
        nCount[mActive] = 0;
        nBusy = 1'b0;
      end else begin
        if (ic) begin
          nCount[mActive] = (mCount[mActive] >= 2047) ? 2047 : mCount[mActive] + 1;
          nBusy = 1'b1;
        end
        if (ef) begin
          nState[mActive] = 2'd2;
          nBusy   = 1'b0;
          nActive = -1;
        end
      end
    end
    s = int'(a[3:2]);
    if (we && !a[4] && !(pulse && (s == mActive))) begin
      if ((a[1:0] == 2'd0) && (di[1:0] < 2'd2) &&
          !(live && (s == mActive) && mBusy)) begin
        nState[s] = di[1:0];
        nCount[s] = 0;
        if (live && (s == mActive) && (di[1:0] == 2'd0))
          nActive = -1;
      end
      if ((a[1:0] == 2'd1) && ((mState[s] == 2'd0) || (mState[s] == 2'd3)))
        nAdr[s] = di[29:0];
    end
    if (mActive < 0) begin
      for (int i = 0; i < 4; i++) begin
        if ((nActive < 0) && (mState[i] == 2'd1)) begin
          nActive = i;
          mRxAdr  = mAdr[i];
          nBusy   = 1'b0;
        end
      end
    end
    mIrq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mState[i] = nState[i];
      mAdr[i]   = nAdr[i];
      mCount[i] = nCount[i];
      if (nState[i] == 2'd2)
        mIrq = 1'b1;
    end
    mActive = nActive;
    mBusy   = nBusy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, check all outputs after the edge
  task automatic applyStimulus(input bit rstn, input bit we, input logic [4:0] a,
                               input logic [31:0] di, input bit rc, input bit ic,
                               input bit ef);
    sys_rst_n     = rstn;
    csr_we        = we;
    csr_a         = a;
    csr_di        = di;
    rx_resetcount = rc;
    rx_incrcount  = ic;
    rx_endframe   = ef;
    modelStep(rstn, we, a, di, rc, ic, ef);
    @(posedge sys_clk);
    #1;
    checkOutput("model.rx_valid", {31'd0, rx_valid}, {31'd0, (mActive >= 0)});
    checkOutput("model.rx_adr", {2'd0, rx_adr}, {2'd0, mRxAdr});
    checkOutput("model.irq_rx", {31'd0, irq_rx}, {31'd0, mIrq});
    checkOutput("model.csr_do", csr_do, mCsrDo);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic csrWrite(input logic [4:0] a, input logic [31:0] d);
    applyStimulus(1'b1, 1'b1, a, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic bytes(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic endFrame();
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic expectReg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    applyStimulus(1'b1, 1'b0, a, 32'd0, 1'b0, 1'b0, 1'b0);
    checkOutput(tag, csr_do, exp);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset.rx_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("reset.irq_rx", {31'd0, irq_rx}, 32'd0);
    checkOutput("reset.csr_do", csr_do, 32'd0);
    idle(3);
    checkOutput("noarm.rx_valid", {31'd0, rx_valid}, 32'd0);

    // Single frame into slot 2
    csrWrite(5'd9, 32'h100);
    csrWrite(5'd8, 32'd1);
    idle(1);
    checkOutput("s2.rx_valid", {31'd0, rx_valid}, 32'd1);
    checkOutput("s2.rx_adr", {2'd0, rx_adr}, 32'h100);
    bytes(64);
    endFrame();
    checkOutput("s2.valid_drop", {31'd0, rx_valid}, 32'd0);
    checkOutput("s2.irq", {31'd0, irq_rx}, 32'd1);
    expectReg("s2.state", 5'd8, 32'd2);
    expectReg("s2.count", 5'd10, 32'd64);
    csrWrite(5'd8, 32'd0);
    idle(1);
    checkOutput("s2.irq_clear", {31'd0, irq_rx}, 32'd0);

    // Slots 1 and 3 served in index order
    csrWrite(5'd5, 32'h200);
    csrWrite(5'd13, 32'h300);
    csrWrite(5'd4, 32'd1);
    csrWrite(5'd12, 32'd1);
    checkOutput("s13.first_adr", {2'd0, rx_adr}, 32'h200);
    bytes(3);
    endFrame();
    checkOutput("s13.gap", {31'd0, rx_valid}, 32'd0);
    idle(1);
    checkOutput("s13.second_valid", {31'd0, rx_valid}, 32'd1);
    checkOutput("s13.second_adr", {2'd0, rx_adr}, 32'h300);
    bytes(2);
    endFrame();
    csrWrite(5'd4, 32'd0);
    expectReg("s13.s1count", 5'd6, 32'd0);
    checkOutput("s13.irq_held", {31'd0, irq_rx}, 32'd1);
    csrWrite(5'd12, 32'd0);
    idle(1);
    checkOutput("s13.irq_clear", {31'd0, irq_rx}, 32'd0);

    // Discard mid-frame with resetcount
    csrWrite(5'd1, 32'h40);
    csrWrite(5'd0, 32'd1);
    idle(1);
    bytes(10);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    expectReg("rc.count", 5'd2, 32'd0);
    expectReg("rc.state", 5'd0, 32'd1);
    expectReg("rc.status", 5'd16, 32'h8);
    checkOutput("rc.adr", {2'd0, rx_adr}, 32'h40);
    bytes(5);
    endFrame();
    expectReg("rc.count5", 5'd2, 32'd5);
    csrWrite(5'd0, 32'd0);

    // Busy slot protected against disarm and re-address
    csrWrite(5'd5, 32'h280);
    csrWrite(5'd4, 32'd1);
    idle(1);
    bytes(2);
    csrWrite(5'd4, 32'd0);
    csrWrite(5'd5, 32'h999);
    expectReg("busy.status", 5'd16, 32'h19);
    endFrame();
    expectReg("busy.adr", 5'd5, 32'h280);
    expectReg("busy.state", 5'd4, 32'd2);
    csrWrite(5'd4, 32'd0);

    // Count saturation and incr+endframe coincidence
    csrWrite(5'd13, 32'h3C0);
    csrWrite(5'd12, 32'd1);
    idle(1);
    bytes(2100);
    endFrame();
    expectReg("sat.count", 5'd14, 32'd2047);
    csrWrite(5'd12, 32'd0);
    csrWrite(5'd0, 32'd1);
    idle(1);
    bytes(3);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    expectReg("coinc.count", 5'd2, 32'd4);
    expectReg("coinc.state", 5'd0, 32'd2);
    csrWrite(5'd0, 32'd0);

    // Reset in the middle of a frame
    csrWrite(5'd9, 32'h123);
    csrWrite(5'd8, 32'd1);
    idle(1);
    bytes(7);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("rst.rx_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("rst.irq", {31'd0, irq_rx}, 32'd0);
    for (int r = 0; r <= 16; r++) expectReg($sformatf("rst.reg%0d", r), 5'(r), 32'd0);
    checkOutput("rst.stay_idle", {31'd0, rx_valid}, 32'd0);
    csrWrite(5'd0, 32'd1);
    idle(1);
    checkOutput("rst.rearm", {31'd0, rx_valid}, 32'd1);

    // Randomized traffic checked against the model every cycle
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(($urandom_range(0, 299) != 0),
                    ($urandom_range(0, 3) == 0),
                    5'($urandom_range(0, 17)),
                    $urandom,
                    ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 1) == 0),
                    ($urandom_range(0, 19) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
